// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control/datapath block.
// Holds the control FSM encoding, the wrap limits of each time field,
// and the field widths used by the top level and the digit counters.
package stopwatch_pkg;

    // Control FSM encoding.
    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Wrap limits: each field counts 0..MAX, then wraps to 0 and carries.
    localparam int MSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Field widths of the time outputs.
    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    // Prescaler width for a given divide ratio. A ratio of 1 still needs one bit.
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_digit_counter.sv
// One stage of the time cascade: a modulo-(MAX+1) counter that advances on
// i_tick and raises o_carry in the same cycle it wraps, so the next stage
// advances on the same clock edge.
module stopwatch_digit_counter #(
    parameter int MAX   = 9,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_tick,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count,
    output logic             o_carry
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count;
    logic             at_max;

    assign at_max  = (count == MAX_V);
    assign o_carry = i_tick && at_max;
    assign o_count = count;

    // Count register: synchronous clear has priority over advance; holds otherwise.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would make the cascade order-dependent.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_tick) begin
            count <= at_max ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl_dp.sv
// Stopwatch control FSM plus prescaler and hh:mm:ss.cc time datapath.
// Consumes single-cycle button pulses; every output is a register.
module stopwatch_ctrl_dp
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_btn_run,
    input  logic                i_btn_clear,
    output logic                o_run,
    output logic [MSEC_W-1:0]   o_msec,
    output logic [SEC_W-1:0]    o_sec,
    output logic [MIN_W-1:0]    o_min,
    output logic [HOUR_W-1:0]   o_hour,
    output logic                o_tick
);

    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int PRE_W = presc_width(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    state_t           state;
    state_t           next_state;
    logic [PRE_W-1:0] prescaler;
    logic             running;
    logic             clearing;
    logic             tick;
    logic             msec_carry;
    logic             sec_carry;
    logic             min_carry;
    logic             hour_carry;

    assign running  = (state == RUN);
    assign clearing = (state == CLEAR);
    assign tick     = running && (prescaler == PRE_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= STOP;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: clear beats run in STOP; clear is ignored in RUN;
    // CLEAR always falls back to STOP after one cycle.
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            STOP: begin
                if (i_btn_clear) begin
                    next_state = CLEAR;
                end else if (i_btn_run) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (i_btn_run) begin
                    next_state = STOP;
                end
            end
            CLEAR:   next_state = STOP;
            default: next_state = STOP;
        endcase
    end

    // Status outputs: o_run tracks the state loaded on the same edge,
    // o_tick is the time-base tick delayed through a flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_run  <= 1'b0;
            o_tick <= 1'b0;
        end else begin
            o_run  <= (next_state == RUN);
            o_tick <= tick;
        end
    end

    // Prescaler: advances only while running and holds while stopped, so the
    // sub-tick fraction survives a pause/resume; CLEAR zeroes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (clearing) begin
            prescaler <= '0;
        end else if (running) begin
            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
        end
    end

    // Time cascade: each stage advances on the carry of the one below it,
    // so a full rollover happens in a single edge.
    stopwatch_digit_counter #(.MAX(MSEC_MAX), .WIDTH(MSEC_W)) u_msec (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (tick),
        .i_clear (clearing),
        .o_count (o_msec),
        .o_carry (msec_carry)
    );

    stopwatch_digit_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (msec_carry),
        .i_clear (clearing),
        .o_count (o_sec),
        .o_carry (sec_carry)
    );

    stopwatch_digit_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (sec_carry),
        .i_clear (clearing),
        .o_count (o_min),
        .o_carry (min_carry)
    );

    // Hour carry wraps 23:59:59.99 to zero with no overflow flag.
    stopwatch_digit_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (min_carry),
        .i_clear (clearing),
        .o_count (o_hour),
        .o_carry (hour_carry)
    );

    // The top of the cascade has nowhere to carry into.
    logic unused_ok;
    assign unused_ok = hour_carry;

endmodule

// File: tb/tb_stopwatch_ctrl_dp.sv
// Self-checking bench for stopwatch_ctrl_dp with DIV=10.
// A behavioural model keeps time as total centiseconds; the expected outputs
// for every cycle are queued when stimulus is driven and compared after the edge.
module tb_stopwatch_ctrl_dp;

    localparam int CLK_FREQ = 1000;
    localparam int TICK_HZ  = 100;
    localparam int DIV      = CLK_FREQ / TICK_HZ;
    localparam int DAY_CS   = 24 * 60 * 60 * 100;

    logic       clk;
    logic       reset;
    logic       btn_run;
    logic       btn_clear;
    logic       run;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       tick;

    stopwatch_ctrl_dp #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_btn_run   (btn_run),
        .i_btn_clear (btn_clear),
        .o_run       (run),
        .o_msec      (msec),
        .o_sec       (sec),
        .o_min       (min),
        .o_hour      (hour),
        .o_tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int run;
        int msec;
        int sec;
        int min;
        int hour;
        int tick;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Model state: 0 stop, 1 run, 2 clear.
    int m_state = 0;
    int m_pre   = 0;
    int m_cs    = 0;
    int m_tick  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.run  = (m_state == 1) ? 1 : 0;
        e.msec = m_cs % 100;
        e.sec  = (m_cs / 100) % 60;
        e.min  = (m_cs / 6000) % 60;
        e.hour = m_cs / 360000;
        e.tick = m_tick;
        return e;
    endfunction

    task automatic model_step(input bit r, input bit c, input bit rst_n);
        int t;
        if (!rst_n) begin
            m_state = 0;
            m_pre   = 0;
            m_cs    = 0;
            m_tick  = 0;
        end else begin
            t = (m_state == 1 && m_pre == DIV - 1) ? 1 : 0;
            if (m_state == 2) begin
                m_pre = 0;
                m_cs  = 0;
            end else if (m_state == 1) begin
                if (t == 1) begin
                    m_pre = 0;
                    m_cs  = (m_cs + 1) % DAY_CS;
                end else begin
                    m_pre = m_pre + 1;
                end
            end
            m_tick = t;
            case (m_state)
                0:       m_state = c ? 2 : (r ? 1 : 0);
                1:       m_state = r ? 0 : 1;
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            check("run",  int'(run),  e.run);
            check("msec", int'(msec), e.msec);
            check("sec",  int'(sec),  e.sec);
            check("min",  int'(min),  e.min);
            check("hour", int'(hour), e.hour);
            check("tick", int'(tick), e.tick);
        end
    endtask

    // One clock: drive inputs, queue the model's expectation, compare after the edge.
    task automatic step(input bit r, input bit c, input bit rst_n);
        btn_run   = r;
        btn_clear = c;
        reset     = rst_n;
        model_step(r, c, rst_n);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    // Idle running cycles until o_tick shows, bounded; returns the cycle count.
    task automatic wait_tick(input string tag, input int limit, output int n);
        n = 0;
        do begin
            step(1'b0, 1'b0, 1'b1);
            n++;
        end while (tick !== 1'b1 && n < limit);
        check(tag, int'(tick), 1);
    endtask

    // Preload the time fields while stopped and mirror the preload in the model.
    task automatic preload(input int h, input int mi, input int s, input int cs);
        force dut.u_msec.count = 7'(cs);
        force dut.u_sec.count  = 6'(s);
        force dut.u_min.count  = 6'(mi);
        force dut.u_hour.count = 5'(h);
        m_cs = ((h * 60 + mi) * 60 + s) * 100 + cs;
        step(1'b0, 1'b0, 1'b1);
        release dut.u_msec.count;
        release dut.u_sec.count;
        release dut.u_min.count;
        release dut.u_hour.count;
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int n;
        int ticks;
        int changed;

        reset     = 1'b0;
        btn_run   = 1'b0;
        btn_clear = 1'b0;

        // Reset held three cycles.
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("rst_run", int'(run), 0);
        check("rst_time", int'({hour, min, sec, msec}), 0);

        // Start: o_run next cycle, first tick after 10 cycles.
        step(1'b1, 1'b0, 1'b1);
        check("start_run", int'(run), 1);
        ticks = 0;
        repeat (10) begin
            step(1'b0, 1'b0, 1'b1);
            ticks += int'(tick);
        end
        check("first_msec", int'(msec), 1);
        check("first_ticks", ticks, 1);

        // 255 running edges in total, then stop: 25 centiseconds, 5 cycles into a tick.
        repeat (244) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check("stop_run", int'(run), 0);
        check("stop_msec", int'(msec), 25);
        changed = 0;
        repeat (100) begin
            step(1'b0, 1'b0, 1'b1);
            if (msec !== 7'd25) changed++;
        end
        check("hold_changes", changed, 0);

        // Resume: the remaining 5 prescaler counts, not a full 10.
        step(1'b1, 1'b0, 1'b1);
        wait_tick("resume_tick", 20, n);
        check("resume_gap", n, 5);
        check("resume_msec", int'(msec), 26);

        // Clear while running has no effect.
        step(1'b0, 1'b1, 1'b1);
        check("clr_in_run", int'(run), 1);
        repeat (12) step(1'b0, 1'b0, 1'b1);
        check("clr_in_run_msec", int'(msec), 27);

        // Stop, then clear: CLEAR for one cycle (buttons ignored), then STOP at zero.
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("clr_state_run", int'(run), 0);
        check("clr_not_yet", int'(msec), 27);
        step(1'b1, 1'b1, 1'b1);
        check("clr_done_run", int'(run), 0);
        check("clr_done_time", int'({hour, min, sec, msec}), 0);
        step(1'b0, 1'b0, 1'b1);
        check("clr_stays_stop", int'(run), 0);

        // Simultaneous run+clear in STOP: clear wins.
        step(1'b1, 1'b0, 1'b1);
        repeat (23) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("both_run", int'(run), 0);
        step(1'b0, 1'b0, 1'b1);
        check("both_run2", int'(run), 0);
        check("both_time", int'({hour, min, sec, msec}), 0);

        // Level-wise toggling on a held run input.
        step(1'b1, 1'b0, 1'b1);
        check("lvl_on", int'(run), 1);
        step(1'b1, 1'b0, 1'b1);
        check("lvl_off", int'(run), 0);
        step(1'b1, 1'b0, 1'b1);
        check("lvl_on2", int'(run), 1);
        step(1'b1, 1'b0, 1'b1);

        // Rollover 00:00:59.99 -> 00:01:00.00.
        preload(0, 0, 59, 99);
        step(1'b1, 1'b0, 1'b1);
        wait_tick("min_tick", 20, n);
        check("min_msec", int'(msec), 0);
        check("min_sec", int'(sec), 0);
        check("min_min", int'(min), 1);

        // Rollover 23:59:59.99 -> 00:00:00.00, still running.
        step(1'b1, 1'b0, 1'b1);
        preload(23, 59, 59, 99);
        step(1'b1, 1'b0, 1'b1);
        wait_tick("day_tick", 20, n);
        check("day_time", int'({hour, min, sec, msec}), 0);
        check("day_run", int'(run), 1);

        // Run to 00:00:03.47, then a one-cycle synchronous reset.
        n = 0;
        while (m_cs != 347 && n < 5000) begin
            step(1'b0, 1'b0, 1'b1);
            n++;
        end
        check("reach_347", m_cs, 347);
        reset = 1'b0;
        #2;
        check("rst_mid_msec", int'(msec), 47);
        check("rst_mid_sec", int'(sec), 3);
        check("rst_mid_run", int'(run), 1);
        step(1'b0, 1'b0, 1'b0);
        check("rst_after_run", int'(run), 0);
        check("rst_after_time", int'({hour, min, sec, msec}), 0);
        repeat (15) step(1'b0, 1'b0, 1'b1);
        check("rst_then_stop", int'(msec), 0);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
